inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
// - Converts symbolic instructions (op, source mode, argument) into 16-bit CPU instruction words.
// - Streams each word as two bytes, with incrementing byte addresses, toward program RAM or the byte-wide I/O pins.
// - Acts as the on-chip assembler back-end: a word it emits, when executed, decodes to exactly the requested op.
// PARAMETERS
// - ADDR_W    8  width of the byte-address counter out_addr
// - HI_FIRST  1  1: emit inst[15:8] first; 0: emit inst[7:0] first
// PORTS
// - clk        in   1       clock; all state updates on its rising edge
// - rst_n      in   1       reset, asynchronous, active-low
// - in_valid   in   1       op/mode/arg are valid
// - in_ready   out  1       encoder can accept a new instruction
// - op         in   4       0 NOP, 1 NOT, 2 OUT_LO, 3 LOAD, 4 ADD, 5 STORE, 6 SUB, 7 AND,
//                           8 OR, 9 XOR, 10 BRANCH, 11 IF; 12-15 illegal
// - mode       in   3       one-arg ops: 0 imm lo, 1 imm hi, 2 data lo, 3 data hi, 4 ram; 5-7 illegal
// - arg        in   11      imm/RAM address in [7:0]; BRANCH offset in [10:0]; IF condition in [1:0]
// - addr_clr   in   1       synchronous: zero address, abort any word in flight
// - out_valid  out  1       out_data/out_addr are valid
// - out_ready  in   1       sink accepts the current byte
// - out_data   out  8       instruction byte
// - out_addr   out  ADDR_W  byte address of out_data
// - inst_word  out  16      last legally encoded word; holds until next legal accept
// - err        out  1       one-cycle pulse on an illegal request
// - err_cnt    out  8       count of illegal requests, saturates at 255
// - wrapped    out  1       sticky: address counter has wrapped past all-ones
// BEHAVIOUR
// - Encoding of inst[15:0]:
//   - NOP 0x0000; NOT 0x0700; OUT_LO 0x0800.
//   - LOAD 0x8000, ADD 0x8800, STORE 0x9000, SUB 0x9800, AND 0xA000, OR 0xA800, XOR 0xB000,
//     each OR'd with {5'b0, mode, arg[7:0]}.
//   - BRANCH 0xC000 | arg[10:0].
//   - IF 0xF000 | cond, with arg[1:0]: 0 -> 0x000 zero, 1 -> 0x001 not-zero, 2 -> 0x010 else, 3 -> 0x011 not-else.
//   - Unused arg bits are ignored.
// - Illegal requests: op 12-15, or a one-arg op with mode 5-7.
// - FSM states: IDLE, BYTE0, BYTE1. in_ready = (state == IDLE); out_valid = (state != IDLE).
// - Accept happens when in_valid && in_ready.
//   - Legal request: latch the word into inst_word and enter BYTE0. out_valid rises the next cycle.
//   - Illegal request: stay in IDLE, pulse err the next cycle, increment err_cnt (saturating), emit no bytes.
// - BYTE0 presents the first byte (chosen by HI_FIRST). BYTE1 presents the other byte.
//   - out_valid && out_ready advances the FSM BYTE0 -> BYTE1 -> IDLE and increments out_addr.
//   - out_data and out_addr stay stable while out_ready is low.
// - Throughput: one word per 3 cycles at best (accept, byte0, byte1).
// - Address counter: modulo 2^ADDR_W. Incrementing from all-ones gives 0 and sets wrapped.
// - addr_clr has priority over every other event in its cycle.
//   - Next cycle: state IDLE, out_addr 0, wrapped 0; the in-flight word is dropped.
//   - in_ready is low in the addr_clr cycle, so no accept happens that cycle.
//   - err_cnt and inst_word are unaffected.
// - Reset (asynchronous, may occur mid-word): state IDLE, out_valid 0, in_ready 1 once rst_n deasserts,
//   out_data 0, out_addr 0, inst_word 0, err 0, err_cnt 0, wrapped 0.
// CONFIGURATION
// - ENC_CHECKSUM_EN defined: adds output csum[7:0], the running XOR of every byte handshaken out.
//   - Cleared to 0 by reset and by addr_clr.
// - ENC_CHECKSUM_EN undefined: no csum port and no checksum logic; all other behaviour is identical.
// TESTING
// - ADD, mode 1, arg 0x5A, out_ready=1, HI_FIRST=1 -> bytes 0x89 @0, 0x5A @1; in_ready high again 3 cycles after accept.
// - BRANCH arg 0x7FF, then IF arg 2 -> inst_word 0xC7FF then 0xF010; bytes C7,FF,F0,10 at addrs 0-3.
// - op 13, then LOAD mode 6 -> two err pulses, err_cnt 2, no out_valid; err_cnt holds at 255 after 300 illegal requests.
// - out_ready held low 5 cycles in BYTE0 -> out_data/out_addr stable; handshake completes on the cycle out_ready rises.
// - Start at out_addr 0xFE, encode NOT -> 0x07 @0xFE, 0x00 @0xFF; out_addr goes to 0x00 and wrapped=1;
//   then addr_clr -> wrapped=0.
// - addr_clr or rst_n low during BYTE1 -> IDLE, out_addr 0, no further byte.
//   - With ENC_CHECKSUM_EN: bytes 0x89,0x5A give csum 0xD3, and csum reads 0 after addr_clr.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: turns symbolic ops into 16-bit instruction words streamed as two addressed bytes.
// Define ENC_CHECKSUM_EN to add csum, a running XOR of every byte handed to the sink.
module inst_encoder #(
    parameter int ADDR_W   = 8,
    parameter bit HI_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [2:0]        mode,
    input  logic [10:0]       arg,
    input  logic              addr_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [15:0]       inst_word,
    output logic              err,
    output logic [7:0]        err_cnt,
    output logic              wrapped
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [7:0]        csum
`endif
);
    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1} state_t;

    state_t            r_state;
    logic [15:0]       r_inst;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;
    logic [7:0]        r_err_cnt;
    logic              r_wrapped;
    logic [15:0]       w_word;
    logic              w_legal;
    logic              w_acc;
    logic              w_hs;
    logic [2:0]        w_alu;
    logic [7:0]        w_first;
    logic [7:0]        w_second;

    // ALU ops 3..9 map to opcode field 0..6; op[2:0]-3 wraps 8,9 to 5,6
    assign w_alu = op[2:0] - 3'd3;

    always_comb begin
        w_word  = 16'h0000;
        w_legal = 1'b1;
        case (op)
            4'd0:    w_word = 16'h0000;
            4'd1:    w_word = 16'h0700;
            4'd2:    w_word = 16'h0800;
            4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
                w_word  = {2'b10, w_alu, mode, arg[7:0]};
                w_legal = (mode <= 3'd4);
            end
            4'd10:   w_word = {5'b11000, arg};
            4'd11:   w_word = {4'hF, 7'd0, arg[1], 3'd0, arg[0]};
            default: w_legal = 1'b0;
        endcase
    end

    assign in_ready  = (r_state == IDLE) && !addr_clr;
    assign out_valid = (r_state != IDLE);
    assign w_acc     = in_valid && in_ready;
    assign w_hs      = out_valid && out_ready;
    assign w_first   = HI_FIRST ? r_inst[15:8] : r_inst[7:0];
    assign w_second  = HI_FIRST ? r_inst[7:0] : r_inst[15:8];
    assign out_data  = (r_state == BYTE0) ? w_first : (r_state == BYTE1) ? w_second : 8'h00;
    assign out_addr  = r_addr;
    assign inst_word = r_inst;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;
    assign wrapped   = r_wrapped;

`ifdef ENC_CHECKSUM_EN
    logic [7:0] r_csum;
    assign csum = r_csum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_inst    <= 16'h0000;
            r_addr    <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'h00;
            r_wrapped <= 1'b0;
`ifdef ENC_CHECKSUM_EN
            r_csum    <= 8'h00;
`endif
        end else if (addr_clr) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_err     <= 1'b0;
            r_wrapped <= 1'b0;
`ifdef ENC_CHECKSUM_EN
            r_csum    <= 8'h00;
`endif
        end else begin
            r_err <= w_acc && !w_legal;
            if (w_acc && !w_legal)
                r_err_cnt <= r_err_cnt + 8'(~&r_err_cnt);
            if (w_acc && w_legal) begin
                r_inst  <= w_word;
                r_state <= BYTE0;
            end else if (w_hs) begin
                r_state <= (r_state == BYTE0) ? BYTE1 : IDLE;
            end
            if (w_hs) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (&r_addr)
                    r_wrapped <= 1'b1;
`ifdef ENC_CHECKSUM_EN
                r_csum <= r_csum ^ out_data;
`endif
            end
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed plus random stimulus checked every cycle against a byte-queue model.
module tb_inst_encoder;
    localparam int AW = 8;
    localparam bit HI = 1'b1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    op = '0;
    logic [2:0]    mode = '0;
    logic [10:0]   arg = '0;
    logic          addr_clr = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic [AW-1:0] out_addr;
    logic [15:0]   inst_word;
    logic          err;
    logic [7:0]    err_cnt;
    logic          wrapped;
`ifdef ENC_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(AW), .HI_FIRST(HI)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .mode(mode), .arg(arg), .addr_clr(addr_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .inst_word(inst_word), .err(err), .err_cnt(err_cnt),
        .wrapped(wrapped)
`ifdef ENC_CHECKSUM_EN
        , .csum(csum)
`endif
    );

    logic [7:0]  q[$];
    int          m_addr;
    logic        m_wrapped;
    logic        m_err;
    logic [15:0] m_inst;
    int          m_cnt;
    logic [7:0]  m_csum;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Returns {legal, word}
    function automatic logic [16:0] enc(input int o, input int md, input int a);
        int w;
        case (o)
            0: w = 0;
            1: w = 'h0700;
            2: w = 'h0800;
            3, 4, 5, 6, 7, 8, 9: begin
                if (md > 4) return 17'h0;
                w = 'h8000 + 'h800 * (o - 3) + md * 256 + (a % 256);
            end
            10: w = 'hC000 + (a % 2048);
            11: w = 'hF000 + (a % 2) + ((a / 2) % 2) * 16;
            default: return 17'h0;
        endcase
        return {1'b1, w[15:0]};
    endfunction

    task automatic mreset();
        q.delete();
        m_addr = 0; m_wrapped = 0; m_err = 0; m_inst = 0; m_cnt = 0; m_csum = 0;
    endtask

    task automatic compare();
        chk("out_valid", out_valid, q.size() != 0);
        chk("out_data", out_data, q.size() != 0 ? q[0] : 8'h00);
        chk("out_addr", out_addr, m_addr);
        chk("in_ready", in_ready, q.size() == 0 && !addr_clr);
        chk("inst_word", inst_word, m_inst);
        chk("err", err, m_err);
        chk("err_cnt", err_cnt, m_cnt);
        chk("wrapped", wrapped, m_wrapped);
`ifdef ENC_CHECKSUM_EN
        chk("csum", csum, m_csum);
`endif
    endtask

    task automatic step();
        logic [16:0] e;
        bit acc;
        if (addr_clr) begin
            q.delete();
            m_addr = 0; m_wrapped = 0; m_err = 0; m_csum = 0;
            return;
        end
        e = enc(op, mode, arg);
        acc = in_valid && q.size() == 0;
        m_err = acc && !e[16];
        if (m_err && m_cnt < 255) m_cnt++;
        if (q.size() != 0 && out_ready) begin
            m_csum ^= q[0];
            void'(q.pop_front());
            if (m_addr == (1 << AW) - 1) m_wrapped = 1;
            m_addr = (m_addr + 1) % (1 << AW);
        end
        if (acc && e[16]) begin
            m_inst = e[15:0];
            if (HI) begin q.push_back(e[15:8]); q.push_back(e[7:0]); end
            else    begin q.push_back(e[7:0]);  q.push_back(e[15:8]); end
        end
    endtask

    task automatic cyc(input logic v, input int o, input int md, input int a, input logic clr, input logic rdy);
        @(negedge clk);
        in_valid = v; op = o[3:0]; mode = md[2:0]; arg = a[10:0]; addr_clr = clr; out_ready = rdy;
        #1;
        compare();
        step();
    endtask

    task automatic areset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        mreset();
        #1;
        compare();
        in_valid = 0; addr_clr = 0; out_ready = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        mreset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst out_data", out_data, 0);
        chk("rst inst_word", inst_word, 0);
        chk("rst err_cnt", err_cnt, 0);
        chk("rst wrapped", wrapped, 0);

        // ADD mode 1 arg 0x5A
        cyc(1, 4, 1, 'h5A, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("add inst", inst_word, 16'h895A);
        chk("add b0", {out_data, out_addr}, 16'h8900);
        cyc(0, 0, 0, 0, 0, 1);
        chk("add b1", {out_data, out_addr}, 16'h5A01);
        cyc(0, 0, 0, 0, 0, 1);
        chk("add ready3", in_ready, 1);
`ifdef ENC_CHECKSUM_EN
        chk("csum d3", csum, 8'hD3);
`endif
        cyc(0, 0, 0, 0, 1, 1);
        // BRANCH then IF
        cyc(1, 10, 0, 'h7FF, 0, 1);
`ifdef ENC_CHECKSUM_EN
        chk("csum clr", csum, 8'h00);
`endif
        cyc(0, 0, 0, 0, 0, 1);
        chk("br inst", inst_word, 16'hC7FF);
        chk("br b0", {out_data, out_addr}, 16'hC700);
        cyc(0, 0, 0, 0, 0, 1);
        chk("br b1", {out_data, out_addr}, 16'hFF01);
        cyc(1, 11, 0, 2, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("if inst", inst_word, 16'hF010);
        chk("if b0", {out_data, out_addr}, 16'hF002);
        cyc(0, 0, 0, 0, 0, 1);
        chk("if b1", {out_data, out_addr}, 16'h1003);
        // illegal requests
        cyc(1, 13, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("ill1", {out_valid, err, err_cnt}, {2'b01, 8'd1});
        cyc(1, 3, 6, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("ill2", {out_valid, err, err_cnt}, {2'b01, 8'd2});
        // stall in BYTE0
        cyc(1, 4, 0, 'h33, 0, 0);
        repeat (5) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("stall", {out_valid, out_data, out_addr}, {1'b1, 16'h8804});
        end
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("stall b1", {out_data, out_addr}, 16'h3305);
        cyc(0, 0, 0, 0, 0, 1);
        // wrap
        cyc(0, 0, 0, 0, 1, 1);
        repeat (127) begin
            cyc(1, 0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 0, 1);
        end
        cyc(1, 1, 0, 0, 0, 1);
        chk("pre-wrap addr", out_addr, 8'hFE);
        cyc(0, 0, 0, 0, 0, 1);
        chk("not b0", {out_data, out_addr}, 16'h07FE);
        cyc(0, 0, 0, 0, 0, 1);
        chk("not b1", {out_data, out_addr}, 16'h00FF);
        cyc(0, 0, 0, 0, 0, 1);
        chk("wrapped", {wrapped, out_addr}, 9'h100);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("wrap clr", wrapped, 0);
        // abort in BYTE1 via addr_clr, then via reset
        cyc(1, 4, 0, 'h11, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("clr abort", {out_valid, out_addr}, 9'h000);
        cyc(1, 4, 0, 'h11, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        areset();
        cyc(0, 0, 0, 0, 0, 1);
        chk("rst abort", {out_valid, out_addr, err_cnt}, 17'h0);
        // saturation
        repeat (300) cyc(1, 12 + $urandom_range(0, 3), 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("sat", err_cnt, 8'd255);
        // random
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 7),
                $urandom_range(0, 2047), $urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
